mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the core's single memory bus between the instruction-fetch port and the load/store port. Honours the decoder's BUS_LOCK control bit, which blocks fetch while a locked data sequence is in flight. Generates byte enables and write-lane replication, aligns and sign-extends load data, and flags misaligned, illegal or timed-out accesses. Sits between the fetch/LSU logic and the external memory interface.

Parameters:
ADDR_W, 32, address width
TIMEOUT, 255, maximum wait cycles for bus_ack before an error is reported (1..2^TO_W-1)
TO_W, 8, width of the timeout counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held with a stable if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch complete
if_rdata  out  32  fetched word; valid while if_gnt is high, held afterwards
if_err  out  1  qualifies if_gnt: misaligned access or timeout
ls_req  in  1  data request; held with stable payload until ls_done
ls_we  in  1  1 = store, 0 = load
ls_funct3  in  3  RV32I size/sign code
ls_addr  in  ADDR_W  byte address
ls_wdata  in  32  store data, LSB-justified
ls_done  out  1  one-cycle pulse: data access complete
ls_rdata  out  32  aligned, extended load result; held after the pulse
ls_err  out  1  qualifies ls_done
bus_lock  in  1  BUS_LOCK bit from the decoder control word
bus_req  out  1  bus cycle request; held until bus_ack or timeout
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word address (bits [1:0] forced to 0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated write data
bus_ack  in  1  bus cycle complete; bus_rdata valid in the same cycle
bus_rdata  in  32  raw read word
busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low. The FSM goes to IDLE and every output is 0, including bus_req; an in-flight bus cycle is abandoned immediately.
- States: IDLE, FETCH, DATA, RESP.
- IDLE arbitration:
  - ls_req wins over if_req.
  - if_req is ignored while bus_lock=1.
  - On grant, the address, we, funct3 and wdata are registered and the state moves to FETCH or DATA.
  - An illegal or misaligned request skips the bus entirely: go straight to RESP with err=1.
- Illegal / misaligned:
  - Loads: funct3 of 3, 6 or 7 is illegal. Stores: funct3 >= 3 is illegal.
  - LH/LHU/SH with addr[0]=1 is misaligned. LW/SW with addr[1:0]!=0 is misaligned.
  - A fetch with if_addr[1:0]!=0 is misaligned.
- FETCH/DATA:
  - bus_req=1 with registered address and controls.
  - The timeout counter clears on state entry and increments each cycle bus_ack=0.
  - bus_ack=1: capture rdata, go to RESP with err=0.
  - Counter reaches TIMEOUT: drop bus_req, go to RESP with err=1, rdata unchanged.
- RESP: pulse the selected done/gnt for exactly one cycle, then return to IDLE. Requests are not sampled in RESP.
- Requester contract: req is low in the cycle after the done/gnt pulse.
- Latency: request in IDLE at cycle 0 → bus_req in cycle 1. An ack in cycle k → done in cycle k+1. Minimum latency is 2 cycles; an error with no bus access takes 1 cycle.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
  - Loads drive 4'b1111.
- Write lanes: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes the word through.
- Load extraction (byte/halfword selected by addr[1:0]):
  - LB 000 and LH 001: sign-extend.
  - LBU 100 and LHU 101: zero-extend.
  - LW 010: word unchanged.
- Bus outputs when idle: bus_we, bus_be and bus_wdata are 0 whenever bus_req=0.
- Simultaneous events:
  - ls_req and if_req together: data first; fetch is granted after RESP if still requested and bus_lock=0.
  - bus_ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins (err=0).
  - bus_lock rising during FETCH does not abort the fetch; it only blocks the next grant.
  - bus_ack outside FETCH/DATA is ignored.

Decomposition:
- Package mem_bus_pkg: the state enum (IDLE, FETCH, DATA, RESP) and the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module ls_align: combinational block computing be, replicated wdata, load extract/extend and the misaligned/illegal flag from funct3, addr[1:0], wdata and rdata.

Test Plan:
- ls_req SB, addr 0x1003, wdata 0xAB, ack after 2 cycles → bus_be=4'b1000, bus_wdata=0xABABABAB, bus_addr=0x1000, ls_done in the cycle after the ack, ls_err=0.
- ls_req LH, addr 0x2002, bus_rdata 0x8001_1234 → ls_rdata=0xFFFF8001; repeat as LHU → ls_rdata=0x00008001.
- if_req and ls_req raised together with bus_lock=1 until the data done → data served first; no fetch bus cycle while the lock is held; fetch is granted once bus_lock=0.
- LW at addr 0x3001 → no bus_req, ls_done with ls_err=1 one cycle after the request; repeat with ls_funct3=3 → error.
- if_req with bus_ack never asserted, TIMEOUT=255 → bus_req drops after 255 wait cycles, if_gnt with if_err=1, FSM back in IDLE.
- rst_n pulled low mid-DATA → bus_req, busy and all done outputs are 0 immediately; the next request after reset is served normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and RV32I
// load/store size codes.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_bus_arbiter_ls_align.sv
// Byte-lane logic for the load/store path: byte enables, store lane
// replication, load extract/extend and the illegal/misaligned flag.
module ls_align
  import mem_bus_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    err       = 1'b0;
    if (we) begin
      case (funct3)
        F3_B: begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_H: begin
          be        = 4'b0011 << addr_lo;
          wdata_rep = {2{wdata[15:0]}};
          err       = addr_lo[0];
        end
        F3_W:    err = |addr_lo;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  rdata_ext = {{24{rd_byte[7]}}, rd_byte};
        F3_BU: rdata_ext = {24'h0, rd_byte};
        F3_H: begin
          rdata_ext = {{16{rd_half[15]}}, rd_half};
          err       = addr_lo[0];
        end
        F3_HU: begin
          rdata_ext = {16'h0, rd_half};
          err       = addr_lo[0];
        end
        F3_W:    err = |addr_lo;
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and load/store,
// honouring BUS_LOCK, with per-cycle ack timeout and error reporting.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  input  logic              bus_lock,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              busy,
  output state_t            dbg_state
);

  // Handshake: a requester holds req with a stable payload until its one-cycle
  // done/gnt pulse and drops req before the following cycle; bus_req is held
  // until bus_ack or until TIMEOUT wait cycles have elapsed.

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              sel_fetch_q;
  logic              err_q;
  logic [TO_W-1:0]   to_cnt;

  logic              is_idle;
  logic              grant_ls;
  logic              grant_if;
  logic              to_hit;
  logic [2:0]        a_f3;
  logic              a_we;
  logic [1:0]        a_lo;
  logic [3:0]        a_be;
  logic [31:0]       a_wdata;
  logic [31:0]       a_rdata;
  logic              a_err;

  assign is_idle  = (state == IDLE);
  assign grant_ls = is_idle && ls_req;
  assign grant_if = is_idle && !ls_req && if_req && !bus_lock;
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1)) && !bus_ack;

  // In IDLE the lane block checks the live request; afterwards it works on
  // the registered payload so be/wdata/extraction stay stable for the cycle.
  assign a_f3 = is_idle ? ls_funct3    : f3_q;
  assign a_we = is_idle ? ls_we        : we_q;
  assign a_lo = is_idle ? ls_addr[1:0] : addr_q[1:0];

  ls_align u_align (
    .funct3    (a_f3),
    .we        (a_we),
    .addr_lo   (a_lo),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .be        (a_be),
    .wdata_rep (a_wdata),
    .rdata_ext (a_rdata),
    .err       (a_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_ls)      state_nx = a_err ? RESP : DATA;
        else if (grant_if) state_nx = (|if_addr[1:0]) ? RESP : FETCH;
      end
      FETCH, DATA: begin
        if (bus_ack || to_hit) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = (state == FETCH) || (state == DATA);
    bus_we    = (state == DATA) && we_q;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = 32'h0;
    if (bus_req) begin
      bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
      bus_be   = a_be;
    end
    if (bus_we) bus_wdata = a_wdata;
    if_gnt  = (state == RESP) && sel_fetch_q;
    ls_done = (state == RESP) && !sel_fetch_q;
    if_err  = if_gnt && err_q;
    ls_err  = ls_done && err_q;
    busy    = !is_idle;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= F3_W;
      wdata_q     <= 32'h0;
      sel_fetch_q <= 1'b0;
      err_q       <= 1'b0;
      to_cnt      <= '0;
      if_rdata    <= 32'h0;
      ls_rdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (grant_ls) begin
            addr_q      <= ls_addr;
            we_q        <= ls_we;
            f3_q        <= ls_funct3;
            wdata_q     <= ls_wdata;
            sel_fetch_q <= 1'b0;
            err_q       <= a_err;
          end else if (grant_if) begin
            addr_q      <= if_addr;
            we_q        <= 1'b0;
            f3_q        <= F3_W;
            wdata_q     <= 32'h0;
            sel_fetch_q <= 1'b1;
            err_q       <= |if_addr[1:0];
          end
        end
        FETCH, DATA: begin
          if (bus_ack) begin
            err_q <= 1'b0;
            if (sel_fetch_q) if_rdata <= bus_rdata;
            else             ls_rdata <= a_rdata;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: store lanes, load extension,
// lock arbitration, error paths, timeout boundary and asynchronous reset.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [2:0]  ls_funct3 = 3'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        bus_lock = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;
  state_t      dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_bus_arbiter #(.ADDR_W(32), .TIMEOUT(255), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .bus_lock(bus_lock), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one data access with a fixed number of no-ack cycles before the ack.
  task automatic drive_ls(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits,
                          output logic done, output logic err);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
    tick();
    repeat (waits) tick();
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    done = ls_done; err = ls_err;
    bus_ack = 1'b0; ls_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    vec_cnt++; if (bus_req !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vec_cnt++; if ({if_gnt, ls_done, if_err, ls_err} !== 4'b0) begin err_cnt++; $display("FAIL rst_pulses got=%b exp=0000", {if_gnt, ls_done, if_err, ls_err}); end
    vec_cnt++; if ({bus_be, bus_wdata, bus_addr} !== 68'h0) begin err_cnt++; $display("FAIL rst_bus got be=%h wd=%h a=%h exp=0", bus_be, bus_wdata, bus_addr); end
    vec_cnt++; if (dbg_state !== IDLE) begin err_cnt++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_lanes();
    // SB at 0x1003 with two no-ack cycles
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_B; ls_addr = 32'h1003; ls_wdata = 32'h0000_00AB;
    tick();
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL sb_req got=%b exp=1", bus_req); end
    vec_cnt++; if (bus_be !== 4'b1000) begin err_cnt++; $display("FAIL sb_be got=%b exp=1000", bus_be); end
    vec_cnt++; if (bus_wdata !== 32'hABAB_ABAB) begin err_cnt++; $display("FAIL sb_wdata got=%h exp=ababab ab", bus_wdata); end
    vec_cnt++; if (bus_addr !== 32'h1000) begin err_cnt++; $display("FAIL sb_addr got=%h exp=00001000", bus_addr); end
    vec_cnt++; if (bus_we !== 1'b1) begin err_cnt++; $display("FAIL sb_we got=%b exp=1", bus_we); end
    tick();
    vec_cnt++; if ({bus_req, ls_done} !== 2'b10) begin err_cnt++; $display("FAIL sb_wait got=%b exp=10", {bus_req, ls_done}); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    vec_cnt++; if ({ls_done, ls_err, bus_req} !== 3'b100) begin err_cnt++; $display("FAIL sb_done got=%b exp=100", {ls_done, ls_err, bus_req}); end
    ls_req = 1'b0;
    tick();
    vec_cnt++; if ({ls_done, busy} !== 2'b00) begin err_cnt++; $display("FAIL sb_idle got=%b exp=00", {ls_done, busy}); end
    vec_cnt++; if ({bus_be, bus_wdata} !== 36'h0) begin err_cnt++; $display("FAIL idle_lanes got be=%b wd=%h exp=0", bus_be, bus_wdata); end

    // SH at 0x2002 and SW at 0x40
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_H; ls_addr = 32'h2002; ls_wdata = 32'h1234_BEEF;
    tick();
    vec_cnt++; if ({bus_be, bus_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin err_cnt++; $display("FAIL sh_lanes got be=%b wd=%h exp be=1100 wd=beefbeef", bus_be, bus_wdata); end
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; ls_req = 1'b0; tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_W; ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF;
    tick();
    vec_cnt++; if ({bus_be, bus_wdata} !== {4'b1111, 32'hDEAD_BEEF}) begin err_cnt++; $display("FAIL sw_lanes got be=%b wd=%h exp be=1111 wd=deadbeef", bus_be, bus_wdata); end
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; ls_req = 1'b0; tick();
  endtask

  task automatic test_load_extend();
    logic d, e;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_H; ls_addr = 32'h2002;
    tick();
    vec_cnt++; if ({bus_we, bus_be, bus_wdata} !== {1'b0, 4'b1111, 32'h0}) begin err_cnt++; $display("FAIL ld_bus got we=%b be=%b wd=%h exp we=0 be=1111 wd=0", bus_we, bus_be, bus_wdata); end
    ls_req = 1'b0; tick(); tick();
    ls_req = 1'b0;
    // the access above times out only after many cycles; finish it with an ack
    bus_ack = 1'b1; bus_rdata = 32'h8001_1234; ls_req = 1'b1; tick(); bus_ack = 1'b0; ls_req = 1'b0; tick();
    vec_cnt++; if (ls_rdata !== 32'hFFFF_8001) begin err_cnt++; $display("FAIL lh_data got=%h exp=ffff8001", ls_rdata); end
    drive_ls(1'b0, F3_HU, 32'h2002, 32'h0, 32'h8001_1234, 0, d, e);
    vec_cnt++; if ({d, e, ls_rdata} !== {2'b10, 32'h0000_8001}) begin err_cnt++; $display("FAIL lhu_data got done=%b err=%b d=%h exp 1 0 00008001", d, e, ls_rdata); end
    drive_ls(1'b0, F3_B, 32'h2003, 32'h0, 32'h8001_1234, 1, d, e);
    vec_cnt++; if (ls_rdata !== 32'hFFFF_FF80) begin err_cnt++; $display("FAIL lb_data got=%h exp=ffffff80", ls_rdata); end
    drive_ls(1'b0, F3_BU, 32'h2001, 32'h0, 32'h8001_1234, 0, d, e);
    vec_cnt++; if (ls_rdata !== 32'h0000_0012) begin err_cnt++; $display("FAIL lbu_data got=%h exp=00000012", ls_rdata); end
    drive_ls(1'b0, F3_W, 32'h2000, 32'h0, 32'h8001_1234, 3, d, e);
    vec_cnt++; if ({d, e, ls_rdata} !== {2'b10, 32'h8001_1234}) begin err_cnt++; $display("FAIL lw_data got done=%b err=%b d=%h exp 1 0 80011234", d, e, ls_rdata); end
  endtask

  task automatic test_errors();
    // misaligned LW: straight to RESP, no bus cycle, data held
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 32'h3001;
    tick();
    vec_cnt++; if ({ls_done, ls_err, bus_req} !== 3'b110) begin err_cnt++; $display("FAIL lw_mis got=%b exp=110", {ls_done, ls_err, bus_req}); end
    vec_cnt++; if (ls_rdata !== 32'h8001_1234) begin err_cnt++; $display("FAIL err_hold got=%h exp=80011234", ls_rdata); end
    ls_req = 1'b0; tick();
    ls_req = 1'b1; ls_funct3 = 3'd3; ls_addr = 32'h3000;
    tick();
    vec_cnt++; if ({ls_done, ls_err, bus_req} !== 3'b110) begin err_cnt++; $display("FAIL ld_f3_3 got=%b exp=110", {ls_done, ls_err, bus_req}); end
    ls_req = 1'b0; tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_H; ls_addr = 32'h3001;
    tick();
    vec_cnt++; if ({ls_done, ls_err, bus_req} !== 3'b110) begin err_cnt++; $display("FAIL sh_mis got=%b exp=110", {ls_done, ls_err, bus_req}); end
    ls_req = 1'b0; tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = F3_BU; ls_addr = 32'h3000;
    tick();
    vec_cnt++; if ({ls_done, ls_err} !== 2'b11) begin err_cnt++; $display("FAIL st_f3_4 got=%b exp=11", {ls_done, ls_err}); end
    ls_req = 1'b0; ls_we = 1'b0; tick();
    if_req = 1'b1; if_addr = 32'h0102;
    tick();
    vec_cnt++; if ({if_gnt, if_err, bus_req, ls_done} !== 4'b1100) begin err_cnt++; $display("FAIL if_mis got=%b exp=1100", {if_gnt, if_err, bus_req, ls_done}); end
    if_req = 1'b0; tick();
    // stray ack while idle is ignored
    bus_ack = 1'b1; tick(); bus_ack = 1'b0;
    vec_cnt++; if ({busy, ls_done, if_gnt} !== 3'b000) begin err_cnt++; $display("FAIL idle_ack got=%b exp=000", {busy, ls_done, if_gnt}); end
  endtask

  task automatic test_lock_arbitration();
    int waited;
    bus_lock = 1'b1;
    if_req = 1'b1; if_addr = 32'h0400;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 32'h0500;
    tick();
    vec_cnt++; if ({dbg_state, bus_addr} !== {DATA, 32'h0500}) begin err_cnt++; $display("FAIL prio_data got st=%0d a=%h exp st=2 a=00000500", dbg_state, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 1'b0; ls_req = 1'b0;
    vec_cnt++; if ({ls_done, if_gnt} !== 2'b10) begin err_cnt++; $display("FAIL lock_done got=%b exp=10", {ls_done, if_gnt}); end
    waited = 0;
    repeat (4) begin
      tick();
      if (bus_req) waited++;
    end
    vec_cnt++; if (waited !== 0) begin err_cnt++; $display("FAIL lock_block got=%0d bus cycles exp=0", waited); end
    bus_lock = 1'b0;
    tick();
    vec_cnt++; if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h0400, 4'b1111}) begin err_cnt++; $display("FAIL fetch_go got r=%b a=%h be=%b exp 1 00000400 1111", bus_req, bus_addr, bus_be); end
    bus_lock = 1'b1;
    tick();
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL lock_no_abort got=%b exp=1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'h0011_2233;
    tick();
    bus_ack = 1'b0; if_req = 1'b0;
    vec_cnt++; if ({if_gnt, if_err, if_rdata} !== {2'b10, 32'h0011_2233}) begin err_cnt++; $display("FAIL fetch_gnt got g=%b e=%b d=%h exp 1 0 00112233", if_gnt, if_err, if_rdata); end
    bus_lock = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 32'h0800;
    tick();
    repeat (254) tick();
    vec_cnt++; if (bus_req !== 1'b1) begin err_cnt++; $display("FAIL to_req255 got=%b exp=1", bus_req); end
    tick();
    vec_cnt++; if ({bus_req, if_gnt, if_err} !== 3'b011) begin err_cnt++; $display("FAIL to_err got=%b exp=011", {bus_req, if_gnt, if_err}); end
    vec_cnt++; if (if_rdata !== 32'h0011_2233) begin err_cnt++; $display("FAIL to_hold got=%h exp=00112233", if_rdata); end
    if_req = 1'b0;
    tick();
    vec_cnt++; if ({busy, dbg_state} !== {1'b0, IDLE}) begin err_cnt++; $display("FAIL to_idle got busy=%b st=%0d exp 0 0", busy, dbg_state); end
    // ack on the final wait cycle beats the timeout
    if_req = 1'b1; if_addr = 32'h0900;
    tick();
    repeat (254) tick();
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_C0DE;
    tick();
    bus_ack = 1'b0; if_req = 1'b0;
    vec_cnt++; if ({if_gnt, if_err, if_rdata} !== {2'b10, 32'h0BAD_C0DE}) begin err_cnt++; $display("FAIL ack_wins got g=%b e=%b d=%h exp 1 0 0badc0de", if_gnt, if_err, if_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic d, e;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 32'h0600;
    tick(); tick();
    #2 rst_n = 1'b0; ls_req = 1'b0;
    #1;
    vec_cnt++; if ({bus_req, busy, ls_done, if_gnt} !== 4'b0000) begin err_cnt++; $display("FAIL mid_rst got=%b exp=0000", {bus_req, busy, ls_done, if_gnt}); end
    vec_cnt++; if ({ls_rdata, if_rdata} !== 64'h0) begin err_cnt++; $display("FAIL mid_rst_data got ls=%h if=%h exp=0", ls_rdata, if_rdata); end
    #2 rst_n = 1'b1;
    tick();
    drive_ls(1'b0, F3_W, 32'h0600, 32'h0, 32'hCAFE_F00D, 1, d, e);
    vec_cnt++; if ({d, e, ls_rdata} !== {2'b10, 32'hCAFE_F00D}) begin err_cnt++; $display("FAIL post_rst got done=%b err=%b d=%h exp 1 0 cafef00d", d, e, ls_rdata); end
  endtask

  initial begin
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_errors();
    test_lock_arbitration();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
